// File: rtl/cpu_types_pkg.sv
// ============================================================================
// cpu_types_pkg : shared CPU types (register fields, hazard controller state)
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } hazard_state_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// ============================================================================
// hazard_detect : load-use compare between ID/EX load target and IF/ID sources
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic     i_idex_memread,
    input  regbits_t i_idex_rt,
    input  regbits_t i_ifid_rs,
    input  regbits_t i_ifid_rt,
    output logic     o_load_use
);

    // $zero is never a real dependency, so a load into r0 never stalls
    assign o_load_use = i_idex_memread && (i_idex_rt != 5'd0) &&
                        ((i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt));

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl : PC/stage enable and flush sequencing for 5-stage MIPS
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
)(
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_dren,
    input  logic             exmem_dwen,
    input  logic             idex_memread,
    input  regbits_t         idex_rt,
    input  regbits_t         ifid_rs,
    input  regbits_t         ifid_rt,
    input  logic             ex_redirect,
    input  logic             ex_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int            c_DRN_W     = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [c_DRN_W-1:0] c_DRN_INIT = c_DRN_W'(DRAIN_CYCLES);
    localparam logic [c_DRN_W-1:0] c_DRN_ONE  = c_DRN_W'(1);

    hazard_state_t       r_state;
    hazard_state_t       w_next_state;
    logic [c_DRN_W-1:0]  r_drain_cnt;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic                w_load_use;
    logic                w_dfreeze;
    logic                w_drain_load;
    logic                w_drain_dec;

    logic w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
    logic w_ifid_flush, w_idex_flush;

    hazard_detect u_hazard_detect (
        .i_idex_memread (idex_memread),
        .i_idex_rt      (idex_rt),
        .i_ifid_rs      (ifid_rs),
        .i_ifid_rt      (ifid_rt),
        .o_load_use     (w_load_use)
    );

    // Data side owns the shared memory port: an outstanding data access freezes everything
    assign w_dfreeze = (exmem_dren || exmem_dwen) && !dhit;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= RUN;
            r_drain_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_drain_load)
                r_drain_cnt <= c_DRN_INIT;
            else if (w_drain_dec)
                r_drain_cnt <= r_drain_cnt - c_DRN_ONE;
            if ((r_state != HALTED) && !w_pc_en && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_drain_load = 1'b0;
        w_drain_dec  = 1'b0;
        case (r_state)
            RUN, MEMWAIT: begin
                if (w_dfreeze) begin
                    w_next_state = MEMWAIT;
                end else if (ex_halt) begin
                    w_next_state = DRAIN;
                    w_drain_load = 1'b1;
                end else begin
                    w_next_state = RUN;
                end
            end
            DRAIN: begin
                if (!w_dfreeze) begin
                    w_drain_dec = (r_drain_cnt != '0);
                    if (r_drain_cnt <= c_DRN_ONE)
                        w_next_state = HALTED;
                end
            end
            default: w_next_state = HALTED;
        endcase
    end

    always_comb begin
        w_pc_en      = 1'b0;
        w_ifid_en    = 1'b0;
        w_idex_en    = 1'b0;
        w_exmem_en   = 1'b0;
        w_memwb_en   = 1'b0;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        case (r_state)
            RUN, MEMWAIT: begin
                if (!w_dfreeze) begin
                    w_exmem_en = 1'b1;
                    w_memwb_en = 1'b1;
                    if (ex_halt || ex_redirect) begin
                        // Redirect refetches from the resolved target even on a fetch miss
                        w_pc_en      = ex_redirect && !ex_halt;
                        w_ifid_en    = 1'b1;
                        w_idex_en    = 1'b1;
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                    end else if (w_load_use) begin
                        w_idex_en    = 1'b1;
                        w_idex_flush = 1'b1;
                    end else if (!ihit) begin
                        w_ifid_en    = 1'b1;
                        w_ifid_flush = 1'b1;
                        w_idex_en    = 1'b1;
                    end else begin
                        w_pc_en   = 1'b1;
                        w_ifid_en = 1'b1;
                        w_idex_en = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!w_dfreeze) begin
                    w_ifid_en    = 1'b1;
                    w_idex_en    = 1'b1;
                    w_exmem_en   = 1'b1;
                    w_memwb_en   = 1'b1;
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign pc_en       = w_pc_en;
    assign ifid_en     = w_ifid_en;
    assign idex_en     = w_idex_en;
    assign exmem_en    = w_exmem_en;
    assign memwb_en    = w_memwb_en;
    assign ifid_flush  = w_ifid_flush;
    assign idex_flush  = w_idex_flush;
    assign exmem_flush = 1'b0;
    assign halt        = (r_state == HALTED);
    assign stall_cnt   = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// tb_pipeline_hazard_ctrl : directed + randomized check against a rule model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

    localparam int DRAIN_CYCLES = 2;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             nRST = 1'b0;
    logic             ihit = 1'b1, dhit = 1'b0;
    logic             exmem_dren = 1'b0, exmem_dwen = 1'b0;
    logic             idex_memread = 1'b0, ex_redirect = 1'b0, ex_halt = 1'b0;
    logic [4:0]       idex_rt = '0, ifid_rs = '0, ifid_rt = '0;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, exmem_flush, halt;
    logic [CNT_W-1:0] stall_cnt;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .exmem_dren(exmem_dren), .exmem_dwen(exmem_dwen),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ex_redirect(ex_redirect), .ex_halt(ex_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .halt(halt), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: processor phase flags and counters, not FSM states
    bit m_halted = 0, m_draining = 0;
    int m_left = 0, m_stall = 0;
    bit x_halted, x_draining;
    int x_left, x_stall;
    int halted_cycles = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] observed();
        return {23'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, halt};
    endfunction

    task automatic model_eval(output logic [31:0] exp_o);
        bit pc = 0, ie = 0, de = 0, ee = 0, me = 0, ifl = 0, dfl = 0, h = 0;
        bit lu;
        x_halted = m_halted; x_draining = m_draining; x_left = m_left; x_stall = m_stall;
        lu = idex_memread && (idex_rt != 0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
        if (m_halted) begin
            h = 1;
        end else begin
            if (!((exmem_dren || exmem_dwen) && !dhit)) begin
                if (m_draining) begin
                    ie = 1; de = 1; ee = 1; me = 1; ifl = 1; dfl = 1;
                    if (m_left <= 1) begin x_halted = 1; x_draining = 0; end
                    else x_left = m_left - 1;
                end else begin
                    ee = 1; me = 1;
                    if (ex_halt) begin
                        ie = 1; de = 1; ifl = 1; dfl = 1;
                        x_draining = 1; x_left = DRAIN_CYCLES;
                    end else if (ex_redirect) begin
                        pc = 1; ie = 1; de = 1; ifl = 1; dfl = 1;
                    end else if (lu) begin
                        de = 1; dfl = 1;
                    end else if (!ihit) begin
                        ie = 1; ifl = 1; de = 1;
                    end else begin
                        pc = 1; ie = 1; de = 1;
                    end
                end
            end
            if (!pc && m_stall < CNT_MAX) x_stall = m_stall + 1;
        end
        exp_o = {23'd0, pc, ie, de, ee, me, ifl, dfl, 1'b0, h};
    endtask

    task automatic cycle(input logic ih, input logic dh, input logic dr, input logic dw,
                         input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic rd, input logic hl);
        logic [31:0] e;
        @(negedge CLK);
        ihit = ih; dhit = dh; exmem_dren = dr; exmem_dwen = dw; idex_memread = mr;
        idex_rt = xrt; ifid_rs = rs; ifid_rt = rt; ex_redirect = rd; ex_halt = hl;
        #1;
        model_eval(e);
        check("ctl", observed(), e);
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        @(posedge CLK);
        m_halted = x_halted; m_draining = x_draining; m_left = x_left; m_stall = x_stall;
        halted_cycles = m_halted ? halted_cycles + 1 : 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset is raised away from any clock edge so its asynchronous effect is observed
    task automatic do_reset();
        logic [31:0] e;
        @(negedge CLK);
        ihit = 1; dhit = 0; exmem_dren = 0; exmem_dwen = 0; idex_memread = 0;
        idex_rt = 0; ifid_rs = 0; ifid_rt = 0; ex_redirect = 0; ex_halt = 0;
        nRST = 0;
        #1;
        m_halted = 0; m_draining = 0; m_left = 0; m_stall = 0; halted_cycles = 0;
        model_eval(e);
        check("rst_ctl", observed(), e);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        check("rst_halt", 32'(halt), 32'd0);
        @(posedge CLK);
        #1 nRST = 1;
    endtask

    initial begin
        do_reset();
        idle(3);

        // Data miss freeze then release
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Load-use, then load into r0
        cycle(1, 0, 0, 0, 1, 5, 5, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 7, 1, 7, 0, 0);

        // Redirect beats load-use and fetch miss
        cycle(0, 0, 0, 0, 1, 5, 5, 5, 1, 0);
        idle(1);

        // Halt, data miss in drain, then sticky halted
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("halt_sticky", 32'(halt), 32'd1);

        // Reset while frozen on a data miss
        do_reset();
        cycle(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        idle(2);

        // Long fetch-miss run saturates the stall counter
        for (int i = 0; i < CNT_MAX + 4; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            if (halted_cycles > 4 || $urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0,
                      $urandom_range(0, 9) < 3, 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
